// File: rtl/barrel_shift_arb.sv
// barrel_shift_arb: round-robin arbiter/sequencer sharing one external
// combinational barrel shifter (ops 0=SRL 1=SRA 2=SLL 3=ROR 4=ROL) among M
// requesters. One operation in flight: IDLE (grant) -> EXEC (shift) -> RESP.
// Optional feature macro: BARREL_SHIFT_ARB_OPCHK_EN adds rsp_err and turns
// op codes above 4 into a flagged passthrough of the captured data.
module barrel_shift_arb #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [M-1:0]              req_valid,
  output logic [M-1:0]              req_ready,
  input  logic [M*N-1:0]            req_data,
  input  logic [M*$clog2(N)-1:0]    req_shamt,
  input  logic [M*3-1:0]            req_op,
  output logic [N-1:0]              sh_data_in,
  output logic [$clog2(N)-1:0]      sh_shift_num,
  output logic [2:0]                sh_op,
  input  logic [N-1:0]              sh_data_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [N-1:0]              rsp_data,
  output logic [$clog2(M)-1:0]      rsp_id,
`ifdef BARREL_SHIFT_ARB_OPCHK_EN
  output logic                      rsp_err,
`endif
  output logic                      busy
);

  localparam int SW = $clog2(N);
  localparam int IW = $clog2(M);
  localparam logic [IW:0]   M_W    = (IW+1)'(M);
  localparam logic [IW-1:0] M_LAST = IW'(M-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    opd_data_q, opd_data_d;
  logic [SW-1:0]   opd_shamt_q, opd_shamt_d;
  logic [2:0]      opd_op_q, opd_op_d;
  logic [IW-1:0]   opd_id_q, opd_id_d;
  logic [N-1:0]    rsp_data_q, rsp_data_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;

  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW:0]     pick;
  logic            op_bad;

  // Round-robin search: first valid requester at or above ptr, wrapping
  // modulo M. Returns {found, index}. Lowest offset wins, so the loop runs
  // downward and the last hit is kept.
  function automatic logic [IW:0] rr_pick(input logic [M-1:0] vld,
                                          input logic [IW-1:0] ptr);
    logic [IW:0]   sum;
    logic          found;
    logic [IW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = M-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= M_W) sum = sum - M_W;
      if (vld[sum[IW-1:0]]) begin
        found = 1'b1;
        idx   = sum[IW-1:0];
      end
    end
    return {found, idx};
  endfunction

  // Next pointer after a grant: one past the winner, wrapping at M.
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (g == M_LAST) ? '0 : g + 1'b1;
  endfunction

  // Arbitration result for the current cycle.
  always_comb begin
    pick      = rr_pick(req_valid, rr_ptr_q);
    grant_vld = pick[IW];
    grant_idx = pick[IW-1:0];
  end

`ifdef BARREL_SHIFT_ARB_OPCHK_EN
  logic rsp_err_q, rsp_err_d;

  // Op codes above ROL are not shifted; the operation becomes a flagged
  // passthrough with the shifter held on op 0.
  always_comb begin
    op_bad = (opd_op_q > 3'd4);
  end
`else
  // Without op checking every op code goes to the shifter as captured.
  always_comb begin
    op_bad = 1'b0;
  end
`endif

  // Shifter operands come straight from the operand registers, so they stay
  // constant for the whole operation and are zero out of reset.
  always_comb begin
    sh_data_in   = opd_data_q;
    sh_shift_num = opd_shamt_q;
    sh_op        = op_bad ? 3'd0 : opd_op_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the accept strobe exists only in IDLE, the response only in RESP.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Datapath next values: capture the granted slice in IDLE, the shifter
  // result in EXEC, hold otherwise.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    opd_data_d  = opd_data_q;
    opd_shamt_d = opd_shamt_q;
    opd_op_d    = opd_op_q;
    opd_id_d    = opd_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
`ifdef BARREL_SHIFT_ARB_OPCHK_EN
    rsp_err_d   = rsp_err_q;
`endif
    // stage: handshake cycle, operands into the operand registers
    if (state_q == IDLE && grant_vld) begin
      opd_data_d  = req_data[grant_idx*N +: N];
      opd_shamt_d = req_shamt[grant_idx*SW +: SW];
      opd_op_d    = req_op[grant_idx*3 +: 3];
      opd_id_d    = grant_idx;
      rr_ptr_d    = rr_next(grant_idx);
    end
    // stage: shift cycle, shifter result into the response registers
    if (state_q == EXEC) begin
      rsp_data_d = op_bad ? opd_data_q : sh_data_out;
      rsp_id_d   = opd_id_q;
`ifdef BARREL_SHIFT_ARB_OPCHK_EN
      rsp_err_d  = op_bad;
`endif
    end
  end

  // Datapath and pointer registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      opd_data_q  <= '0;
      opd_shamt_q <= '0;
      opd_op_q    <= '0;
      opd_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      opd_data_q  <= opd_data_d;
      opd_shamt_q <= opd_shamt_d;
      opd_op_q    <= opd_op_d;
      opd_id_q    <= opd_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef BARREL_SHIFT_ARB_OPCHK_EN
  // Error flag travels with the response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;
`endif

  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Directed bench for barrel_shift_arb (N=32, M=4) with a behavioural shifter
// standing in for the external barrel_shift instance.
module tb_barrel_shift_arb;
  localparam int N  = 32;
  localparam int M  = 4;
  localparam int SW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [M-1:0]      req_valid;
  logic [M-1:0]      req_ready;
  logic [M*N-1:0]    req_data;
  logic [M*SW-1:0]   req_shamt;
  logic [M*3-1:0]    req_op;
  logic [N-1:0]      sh_data_in;
  logic [SW-1:0]     sh_shift_num;
  logic [2:0]        sh_op;
  logic [N-1:0]      sh_data_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;
`ifdef BARREL_SHIFT_ARB_OPCHK_EN
  logic              rsp_err;
`endif

  logic [3:0]  vld;
  logic [31:0] dat [M];
  logic [4:0]  sha [M];
  logic [2:0]  opc [M];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  barrel_shift_arb #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_shamt    (req_shamt),
    .req_op       (req_op),
    .sh_data_in   (sh_data_in),
    .sh_shift_num (sh_shift_num),
    .sh_op        (sh_op),
    .sh_data_out  (sh_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
`ifdef BARREL_SHIFT_ARB_OPCHK_EN
    .rsp_err      (rsp_err),
`endif
    .busy         (busy)
  );

  // Pack the per-requester stimulus into the flattened ports.
  always_comb begin
    req_valid = vld;
    for (int i = 0; i < M; i++) begin
      req_data[i*N +: N]   = dat[i];
      req_shamt[i*SW +: SW] = sha[i];
      req_op[i*3 +: 3]     = opc[i];
    end
  end

  // Behavioural shifter; unknown ops pass data through.
  always_comb begin
    case (sh_op)
      3'd0:    sh_data_out = sh_data_in >> sh_shift_num;
      3'd1:    sh_data_out = $signed(sh_data_in) >>> sh_shift_num;
      3'd2:    sh_data_out = sh_data_in << sh_shift_num;
      3'd3:    sh_data_out = (sh_data_in >> sh_shift_num) | (sh_data_in << (32 - sh_shift_num));
      3'd4:    sh_data_out = (sh_data_in << sh_shift_num) | (sh_data_in >> (32 - sh_shift_num));
      default: sh_data_out = sh_data_in;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One full operation starting from an IDLE cycle: grant check, EXEC check,
  // then RESP held for 'hold' cycles with rsp_ready low before acceptance.
  task automatic txn(input string tag, input int id, input logic [31:0] res,
                     input int hold, input bit drop, input bit err);
    logic [2:0] exp_op;
    @(negedge clk);
    check({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    adv();
    if (drop) vld[id] = 1'b0;
    @(negedge clk);
`ifdef BARREL_SHIFT_ARB_OPCHK_EN
    exp_op = err ? 3'd0 : opc[id];
`else
    exp_op = opc[id];
`endif
    check({tag, "_busy_exec"}, 32'(busy), 32'd1);
    check({tag, "_ready_exec"}, 32'(req_ready), 32'd0);
    check({tag, "_valid_exec"}, 32'(rsp_valid), 32'd0);
    check({tag, "_sh_data"}, sh_data_in, dat[id]);
    check({tag, "_sh_op"}, 32'(sh_op), 32'(exp_op));
    if (hold > 0) rsp_ready = 1'b0;
    adv();
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_rsp_data"}, rsp_data, res);
      check({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_ready_resp"}, 32'(req_ready), 32'd0);
`ifdef BARREL_SHIFT_ARB_OPCHK_EN
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'(err));
`endif
      adv();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    vld       = 4'b0000;
    dat[0] = 32'h0000_00F0; sha[0] = 5'd4;  opc[0] = 3'd0;
    dat[1] = 32'h0000_0001; sha[1] = 5'd31; opc[1] = 3'd2;
    dat[2] = 32'hF000_0000; sha[2] = 5'd4;  opc[2] = 3'd1;
    dat[3] = 32'h1234_5678; sha[3] = 5'd0;  opc[3] = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_sh_data", sh_data_in, 32'd0);
    check("rst_sh_num", 32'(sh_shift_num), 32'd0);
    check("rst_sh_op", 32'(sh_op), 32'd0);

    // Single SRA request from requester 0.
    adv();
    rst_n = 1'b1;
    dat[0] = 32'h8000_0001; sha[0] = 5'd4; opc[0] = 3'd1;
    vld = 4'b0001;
    txn("sra", 0, 32'hF800_0000, 0, 1'b1, 1'b0);
    @(negedge clk);
    check("sra_valid_after", 32'(rsp_valid), 32'd0);
    check("sra_busy_after", 32'(busy), 32'd0);

    // Fresh reset, then all requesters valid: grants rotate 0,1,2,3,0.
    adv();
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    dat[0] = 32'h0000_00F0; sha[0] = 5'd4; opc[0] = 3'd0;
    vld = 4'b1111;
    txn("rr0", 0, 32'h0000_000F, 0, 1'b0, 1'b0);
    txn("rr1", 1, 32'h8000_0000, 0, 1'b0, 1'b0);
    txn("rr2", 2, 32'hFF00_0000, 0, 1'b0, 1'b0);
    txn("rr3", 3, 32'h1234_5678, 0, 1'b0, 1'b0);
    txn("rr4", 0, 32'h0000_000F, 0, 1'b0, 1'b0);

    // Requester 2 alone with ROL; then 1 and 3 arrive and 3 wins.
    vld = 4'b0100;
    dat[2] = 32'h8000_0001; sha[2] = 5'd1; opc[2] = 3'd4;
    txn("rol", 2, 32'h0000_0003, 0, 1'b1, 1'b0);
    dat[3] = 32'h0000_0001; sha[3] = 5'd8; opc[3] = 3'd2;
    vld = 4'b1010;
    // Response backpressured for 5 cycles while requester 1 waits.
    txn("bp3", 3, 32'h0000_0100, 5, 1'b1, 1'b0);
    txn("bp1", 1, 32'h8000_0000, 0, 1'b1, 1'b0);

    // Reset during EXEC: pointer was 2, so grant 2, then abort.
    vld = 4'b1111;
    @(negedge clk);
    check("abort_grant", 32'(req_ready), 32'b0100);
    adv();
    @(negedge clk);
    check("abort_busy_exec", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_data", rsp_data, 32'd0);
    adv();
    check("abort_valid_held", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    txn("post_rst", 0, 32'h0000_000F, 0, 1'b0, 1'b0);
    // Only requester 0 valid with pointer at 1: wrap-around grant.
    vld = 4'b0001;
    txn("wrap", 0, 32'h0000_000F, 0, 1'b1, 1'b0);

    // Op code above ROL, then an ROR by 8.
    dat[3] = 32'h1234_5678; sha[3] = 5'd4; opc[3] = 3'd6;
    vld = 4'b1000;
    txn("op6", 3, 32'h1234_5678, 0, 1'b1, 1'b1);
    dat[1] = 32'h0000_00FF; sha[1] = 5'd8; opc[1] = 3'd3;
    vld = 4'b0010;
    txn("ror8", 1, 32'hFF00_0000, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
